// File: rtl/bptc_pkg.sv
// Shared definitions for the bptc XOR link: decoder FSM states and the
// default geometry of the encoder/decoder pair.
package bptc_pkg;

  localparam int W_DEF       = 1;
  localparam int KEY_LAT_DEF = 2;
  localparam int DEPTH_DEF   = 4;

  // Register stages between the encoder's Pin input and its Pout outputs.
  localparam int ENC_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/bptc_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a first-word view
// of the head entry; accepts a push into a full FIFO when a pop frees a slot.
module bptc_sync_fifo
  import bptc_pkg::*;
#(
  parameter int W2    = 2 * W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W2-1:0] wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [W2-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] STEP_C = AW'(1);

  logic [W2-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + STEP_C;
      end
      if (do_pop) begin
        rd_q <= rd_q + STEP_C;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/bptc_xor_decoder.sv
// Receive side of the shared-key XOR link: delays the key to line up with the
// encoded pair, strips it off both lanes and queues the result for the consumer.
module bptc_xor_decoder
  import bptc_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int KEY_LAT = KEY_LAT_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key_in,
  input  logic         key_vld,
  input  logic         enc_vld,
  input  logic [W-1:0] enc1,
  input  logic [W-1:0] enc2,
  output logic         dec_vld,
  input  logic         dec_rdy,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic         synced,
  output logic         ovf,
  output logic         early,
  output logic [15:0]  word_cnt
);

  localparam int CW = $clog2(KEY_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(KEY_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [KEY_LAT-1:0][W-1:0] dline_q;
  logic [W-1:0]              key_dly;
  state_e                    state_q;
  logic [CW-1:0]             fill_q;
  logic                      synced_q;
  logic                      ovf_q;
  logic                      ovf_d;
  logic                      early_q;
  logic                      early_d;
  logic [15:0]               word_cnt_q;
  logic [15:0]               word_cnt_d;
  logic                      in_run;
  logic                      push_req;
  logic                      push_ok;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [2*W-1:0]            wdata;
  logic [2*W-1:0]            head;

  // Key delay line; runs every cycle so it is primed by the time RUN is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dline_q <= '0;
    end else begin
      for (int i = KEY_LAT - 1; i > 0; i--) begin
        dline_q[i] <= dline_q[i-1];
      end
      dline_q[0] <= key_in;
    end
  end

  assign key_dly = dline_q[KEY_LAT-1];

  // Sync FSM: the IDLE->FILL cycle counts as the first primed key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      synced_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!key_vld) begin
            state_q  <= ST_IDLE;
            fill_q   <= '0;
            synced_q <= 1'b0;
          end else if (LAT_C == ONE_C) begin
            state_q  <= ST_RUN;
            fill_q   <= LAT_C;
            synced_q <= 1'b1;
          end else begin
            state_q  <= ST_FILL;
            fill_q   <= ONE_C;
            synced_q <= 1'b0;
          end
        end
        ST_FILL: begin
          if (!key_vld) begin
            state_q  <= ST_IDLE;
            fill_q   <= '0;
            synced_q <= 1'b0;
          end else if ((fill_q + ONE_C) == LAT_C) begin
            state_q  <= ST_RUN;
            fill_q   <= LAT_C;
            synced_q <= 1'b1;
          end else begin
            state_q  <= ST_FILL;
            fill_q   <= fill_q + ONE_C;
            synced_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!key_vld) begin
            state_q  <= ST_IDLE;
            fill_q   <= '0;
            synced_q <= 1'b0;
          end else begin
            state_q  <= ST_RUN;
            synced_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          fill_q   <= '0;
          synced_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_run   = (state_q == ST_RUN);
  assign push_req = enc_vld & in_run;
  assign pop      = ~fifo_empty & dec_rdy;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign wdata    = {enc1 ^ key_dly, enc2 ^ key_dly};

  // Sticky error flags and accepted-word counter.
  always_comb begin
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    early_d    = early_q;
    if (push_ok) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (enc_vld && !in_run) begin
      early_d = 1'b1;
    end else begin
      early_d = early_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= 16'd0;
      ovf_q      <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      early_q    <= early_d;
    end
  end

  bptc_sync_fifo #(
    .W2   (2 * W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_ok),
    .pop_i  (pop),
    .wdata_i(wdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  assign dec_vld  = ~fifo_empty;
  assign d1       = head[2*W-1:W];
  assign d2       = head[W-1:0];
  assign synced   = synced_q;
  assign ovf      = ovf_q;
  assign early    = early_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: doc/bptc_xor_decoder.md
# bptc_xor_decoder

Receive-side counterpart of the two-lane shared-key XOR encoder used in the bptc test designs. The encoder registers D1, Pin and D2, emits Pout1 = D1^Pin and Pout2 = Pin^D2, then registers the outputs, giving a fixed 2-cycle key-to-output latency. This block re-times the key stream to match that latency, recovers D1/D2 from the encoded pair, and buffers decoded words in a small FIFO behind a valid/ready output. It sits at the far end of the encoded link and decouples the free-running encoder from a stallable consumer.

## Interface
Parameters:
- W, 1: lane width in bits (encoder uses 1).
- KEY_LAT, 2: key-to-encoded-output latency of the encoder, in cycles; ≥1.
- DEPTH, 4: output FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_in  in  W  raw key (encoder Pin), sampled every cycle.
- key_vld  in  1  key_in is meaningful this cycle.
- enc_vld  in  1  enc1/enc2 carry an encoded word this cycle; no backpressure.
- enc1  in  W  encoded lane 1 (Pout1).
- enc2  in  W  encoded lane 2 (Pout2).
- dec_vld  out  1  FIFO head holds a decoded word.
- dec_rdy  in  1  consumer accepts the head this cycle.
- d1  out  W  recovered D1 at FIFO head.
- d2  out  W  recovered D2 at FIFO head.
- synced  out  1  key pipeline primed (state RUN).
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- early  out  1  sticky: enc_vld was seen while not in RUN.
- word_cnt  out  16  count of words pushed into the FIFO; wraps 0xFFFF→0.

## Operation
- Key delay line: KEY_LAT × W shift register that shifts key_in every cycle, regardless of state; key_d = key_in delayed KEY_LAT cycles.
- Decode: d1 = enc1 ^ key_d, d2 = enc2 ^ key_d; the XOR is combinational into the FIFO write port.
- FSM states: IDLE, FILL, RUN.
  - IDLE → FILL when key_vld = 1.
  - FILL: fill counter increments on each key_vld = 1; when it reaches KEY_LAT, go to RUN. key_vld = 0 in FILL clears the counter and returns to IDLE.
  - RUN: key_vld = 0 → IDLE (counter cleared).
- Push happens when enc_vld = 1 and state = RUN.
  - If the FIFO is full and there is no pop this cycle, the word is dropped and ovf is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- enc_vld = 1 outside RUN: the word is dropped, early is set, and word_cnt does not advance.
- Pop happens when dec_vld & dec_rdy. d1/d2 stay stable while dec_vld = 1 and dec_rdy = 0.
- Simultaneous push and pop on an empty FIFO: the new word is written; the head becomes visible on the next cycle.
- word_cnt increments only on an accepted push.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State → IDLE; delay line, fill counter, FIFO pointers, word_cnt, ovf and early → 0.
  - Outputs after reset: dec_vld = 0, d1 = d2 = 0, synced = 0, ovf = 0, early = 0, word_cnt = 0.
- Reset mid-operation discards all buffered words; no partial word is ever presented.
- synced rises KEY_LAT cycles after the first cycle of continuous key_vld (registered output).
- Decode latency: enc_vld at cycle c into an empty FIFO → dec_vld = 1 at c+1.
- FIFO sustains 1 push and 1 pop per cycle.
- dec_vld, d1, d2, synced, ovf, early and word_cnt are all driven from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package bptc_pkg:
  - state enum (IDLE/FILL/RUN);
  - default W/KEY_LAT/DEPTH constants;
  - ENC_LAT = 2, the encoder latency constant, shared with the encoder test designs.
- One sub-module, bptc_sync_fifo: parameters W2 (= 2·W) and DEPTH; ports push/pop/full/empty/head. The decoder instantiates it once, carrying {d1,d2}.
- Delay line, FSM and counters live in the top module.

## Test plan
- Reset, then key_vld held at 1: synced = 1 exactly at cycle 2. Then key_in = 1 at cycle t and enc1 = 0, enc2 = 1 with enc_vld at t+2 → d1 = 1, d2 = 0 with dec_vld = 1 at t+3.
- With W = 8: drive the encoder model for 100 random (D1, Pin, D2) triples → every decoded pair matches, and word_cnt = 100.
- Hold dec_rdy = 0 and push 5 words with DEPTH = 4 → first 4 retained in order, ovf = 1; word_cnt = 4.
- FIFO full with dec_rdy = 1 and a push in the same cycle → push accepted, ovf stays 0, occupancy stays 4.
- enc_vld during FILL → word dropped, early = 1, dec_vld stays 0. Then key_vld = 0 in RUN → synced = 0 on the next cycle.
- rst_n = 0 for 1 cycle with 3 words buffered → dec_vld = 0, word_cnt = 0 on the next cycle, and all flags cleared.
